// File: rtl/cart_cache.sv
// Direct-mapped, two-channel read cache sitting between the NES PRG/CHR
// fetch paths and the QSPI flash reader. Misses fetch a whole line from
// flash as a byte stream. A flush drops every line and picks a new cart image.
module cart_cache #(
    parameter int          ADDR_W      = 17,
    parameter int          LINE_BYTES  = 8,
    parameter int          NUM_LINES   = 64,
    parameter logic [23:0] FLASH_BASE  = 24'h100000,
    parameter int          INDEX_SHIFT = 18
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [3:0]          index,
    input  logic                flush,
    output logic                busy,
    input  logic [1:0]          ch_req,
    input  logic [2*ADDR_W-1:0] ch_addr,
    output logic [1:0]          ch_ack,
    output logic [15:0]         ch_rdata,
    output logic                mem_req,
    output logic [23:0]         mem_addr,
    input  logic                mem_ready,
    input  logic                mem_valid,
    input  logic [7:0]          mem_data,
    output logic [15:0]         miss_count
);

    localparam int OB = $clog2(LINE_BYTES);
    localparam int LB = $clog2(NUM_LINES);
    localparam int RW = OB + LB;
    localparam int TW = ADDR_W - RW;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        LOOKUP,
        FILL_REQ,
        FILL_DATA,
        REREAD
    } state_t;

    // Miss counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state_q, state_d;
    logic                gnt_q, last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          index_q, pend_idx_q;
    logic                flush_pend_q;
    logic                from_fill_q;
    logic [OB-1:0]       byte_cnt_q;
    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]       tag_mem [NUM_LINES];
    logic [15:0]         miss_q;
    logic [15:0]         held_q;

    logic [7:0]          ram [NUM_LINES*LINE_BYTES];
    logic [7:0]          ram_rdata;
    logic [RW-1:0]       ram_raddr, ram_waddr;
    logic                ram_we;

    logic                grant_ch, do_grant, hit, last_byte, install;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LB-1:0]       line_idx;
    logic [TW-1:0]       addr_tag;
    logic [23:0]         fill_addr;

    // Both requesting: hand the grant to whoever did not get the last one.
    assign grant_ch  = (ch_req == 2'b11) ? ~last_q : ch_req[1];
    assign sel_addr  = grant_ch ? ch_addr[2*ADDR_W-1:ADDR_W] : ch_addr[ADDR_W-1:0];
    assign do_grant  = (state_q == IDLE) && !flush && !flush_pend_q && (ch_req != 2'b00);

    assign line_idx  = addr_q[RW-1:OB];
    assign addr_tag  = addr_q[ADDR_W-1:RW];
    // After a fill the re-read always returns the fetched byte, even when a
    // pending flush kept the line from being installed.
    assign hit       = from_fill_q || (valid_q[line_idx] && (tag_mem[line_idx] == addr_tag));

    assign ram_we    = (state_q == FILL_DATA) && mem_valid;
    assign ram_waddr = {line_idx, byte_cnt_q};
    assign ram_raddr = (state_q == IDLE) ? sel_addr[RW-1:0] : addr_q[RW-1:0];
    assign last_byte = ram_we && (byte_cnt_q == OB'(LINE_BYTES - 1));
    assign install   = last_byte && !flush_pend_q && !flush;

    assign fill_addr = (FLASH_BASE + ({20'd0, index_q} << INDEX_SHIFT))
                     | {{(24-ADDR_W){1'b0}}, addr_q[ADDR_W-1:OB], {OB{1'b0}}};

    assign miss_count = miss_q;

    // Next state and transaction outputs.
    always_comb begin
        state_d  = state_q;
        ch_ack   = 2'b00;
        ch_rdata = held_q;
        mem_req  = 1'b0;
        mem_addr = 24'd0;
        busy     = (state_q != IDLE) || flush_pend_q;
        case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) state_d = FLUSH;
                else if (ch_req != 2'b00)  state_d = LOOKUP;
            end
            FLUSH: state_d = IDLE;
            LOOKUP: begin
                if (hit) begin
                    state_d        = IDLE;
                    ch_ack[gnt_q]  = 1'b1;
                    if (gnt_q) ch_rdata[15:8] = ram_rdata;
                    else       ch_rdata[7:0]  = ram_rdata;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_req  = 1'b1;
                mem_addr = fill_addr;
                if (mem_ready) state_d = FILL_DATA;
            end
            FILL_DATA: if (last_byte) state_d = REREAD;
            REREAD:    state_d = LOOKUP;
            default:   state_d = IDLE;
        endcase
    end

    // Control state: FSM, arbitration, flush bookkeeping, line valid bits, counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            last_q       <= 1'b1;
            index_q      <= 4'd0;
            pend_idx_q   <= 4'd0;
            flush_pend_q <= 1'b0;
            from_fill_q  <= 1'b0;
            byte_cnt_q   <= '0;
            valid_q      <= '0;
            miss_q       <= 16'd0;
            held_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            from_fill_q <= (state_q == REREAD);
            if (do_grant) begin
                gnt_q  <= grant_ch;
                last_q <= grant_ch;
            end
            if (flush) pend_idx_q <= index;
            if (state_q == IDLE)  flush_pend_q <= 1'b0;
            else if (flush)       flush_pend_q <= 1'b1;
            if (state_q == FLUSH) begin
                valid_q <= '0;
                index_q <= pend_idx_q;
            end
            if (ram_we)  byte_cnt_q <= byte_cnt_q + OB'(1);
            if (install) valid_q[line_idx] <= 1'b1;
            if (state_q == LOOKUP) begin
                if (hit) begin
                    if (gnt_q) held_q[15:8] <= ram_rdata;
                    else       held_q[7:0]  <= ram_rdata;
                end else begin
                    miss_q <= sat_inc(miss_q);
                end
            end
        end
    end

    // Latched request address and line tags; guarded by control state, no reset needed.
    always_ff @(posedge clock) begin
        if (do_grant) addr_q <= sel_addr;
        if (install)  tag_mem[line_idx] <= addr_tag;
    end

    // Line data storage, one synchronous read port and one write port.
    always_ff @(posedge clock) begin
        if (ram_we) ram[ram_waddr] <= mem_data;
        ram_rdata <= ram[ram_raddr];
    end

endmodule

// File: tb/tb_cart_cache.sv
// Randomized bench for cart_cache with a transaction-level reference model
// of the cache contents, arbitration order, flush handling and miss counter.
module tb_cart_cache;

    localparam int          ADDR_W      = 17;
    localparam int          LINE_BYTES  = 8;
    localparam int          NUM_LINES   = 64;
    localparam logic [23:0] FLASH_BASE  = 24'h100000;
    localparam int          INDEX_SHIFT = 18;
    localparam int          OB          = 3;

    logic                clock = 1'b0;
    logic                reset_n;
    logic [3:0]          index;
    logic                flush;
    logic                busy;
    logic [1:0]          ch_req;
    logic [2*ADDR_W-1:0] ch_addr;
    logic [1:0]          ch_ack;
    logic [15:0]         ch_rdata;
    logic                mem_req;
    logic [23:0]         mem_addr;
    logic                mem_ready;
    logic                mem_valid;
    logic [7:0]          mem_data;
    logic [15:0]         miss_count;

    cart_cache #(
        .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .NUM_LINES(NUM_LINES),
        .FLASH_BASE(FLASH_BASE), .INDEX_SHIFT(INDEX_SHIFT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .index(index), .flush(flush), .busy(busy),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_ack(ch_ack), .ch_rdata(ch_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
        .mem_valid(mem_valid), .mem_data(mem_data), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Flash image content: every byte derived from its own flash address.
    function automatic logic [7:0] fb(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    function automatic logic [23:0] exp_faddr(input logic [16:0] ad, input logic [3:0] ix);
        logic [23:0] base;
        base = FLASH_BASE + (24'(ix) << INDEX_SHIFT);
        return base | (24'(ad) & ~24'(LINE_BYTES - 1));
    endfunction

    function automatic logic [16:0] pick();
        logic [7:0] t;
        case ($urandom % 4)
            0:       t = 8'h00;
            1:       t = 8'h01;
            2:       t = 8'h80;
            default: t = 8'hFF;
        endcase
        return {t, 6'($urandom % 4), 3'($urandom)};
    endfunction

    // Reference model: line number -> cached line address (addr >> OB).
    int unsigned cl [int];
    logic [3:0]  m_idx, m_cap;
    int          m_miss;
    bit          m_last;
    bit          m_fpend;
    logic [15:0] m_held;
    logic [1:0]  pend;
    logic [16:0] a [2];

    task automatic reset_model();
        cl.delete();
        m_idx = 4'd0; m_cap = 4'd0; m_miss = 0; m_last = 1'b1;
        m_fpend = 1'b0; m_held = 16'd0;
    endtask

    // Flash reader: accept after a random delay, stream the line with gaps,
    // and throw stray strobes while no fill is running.
    int          bk_ph, bk_cnt, bk_i;
    logic [23:0] bk_addr;
    initial begin
        bk_ph = 0; bk_cnt = 0; bk_i = 0; bk_addr = 24'd0;
        mem_ready = 1'b0; mem_valid = 1'b0; mem_data = 8'd0;
        forever begin
            @(posedge clock); #2;
            mem_ready = 1'b0; mem_valid = 1'b0; mem_data = 8'($urandom);
            if (!reset_n) bk_ph = 0;
            else if (bk_ph == 0) begin
                if (mem_req) begin bk_cnt = $urandom_range(0, 3); bk_ph = 1; end
                else if ($urandom % 4 == 0) mem_valid = 1'b1;
            end else if (bk_ph == 2) begin
                if ($urandom % 3 != 0) begin
                    mem_valid = 1'b1;
                    mem_data  = fb(bk_addr + 24'(bk_i));
                    bk_i++;
                    if (bk_i == LINE_BYTES) bk_ph = 0;
                end
            end
            if (reset_n && bk_ph == 1) begin
                if (bk_cnt == 0) begin
                    mem_ready = 1'b1; bk_addr = mem_addr; bk_i = 0; bk_ph = 2;
                end else bk_cnt--;
            end
        end
    end

    // One decision cycle with the DUT idle; entered and left at posedge+1.
    task automatic step(input bit fill_flush);
        bit          g, hit;
        int          line, k, fl_at;
        logic [16:0] ad;
        logic [23:0] fa;
        logic [7:0]  eb;
        ch_req  = pend;
        ch_addr = {a[1], a[0]};
        @(negedge clock);
        check("idle_ack", 32'(ch_ack), 32'(0));
        check("idle_busy", 32'(busy), 32'(m_fpend));
        if (flush || m_fpend) begin
            if (flush) m_cap = index;
            @(posedge clock); #1;
            flush = 1'b0;
            @(negedge clock);
            check("flush_busy", 32'(busy), 32'(1));
            check("flush_ack", 32'(ch_ack), 32'(0));
            cl.delete(); m_idx = m_cap; m_fpend = 1'b0;
            @(posedge clock); #1;
        end else if (pend != 2'b00) begin
            g      = (pend == 2'b11) ? ~m_last : pend[1];
            m_last = g;
            ad     = a[g];
            line   = int'((ad >> OB) % NUM_LINES);
            hit    = cl.exists(line) && (cl[line] == int'(ad >> OB));
            fa     = exp_faddr(ad, m_idx);
            @(posedge clock); #1;
            @(negedge clock);
            if (!hit) begin
                check("miss_noack", 32'(ch_ack), 32'(0));
                if (m_miss < 65535) m_miss++;
                @(posedge clock); #1;
                @(negedge clock);
                check("fill_req", 32'(mem_req), 32'(1));
                check("fill_addr", 32'(mem_addr), 32'(fa));
                check("miss_cnt", 32'(miss_count), 32'(m_miss));
                fl_at = fill_flush ? $urandom_range(0, 7) : -1;
                k = 0;
                while (ch_ack == 2'b00 && k < 80) begin
                    @(posedge clock); #1;
                    if (k == fl_at) begin
                        flush = 1'b1; index = 4'($urandom); m_fpend = 1'b1; m_cap = index;
                    end else flush = 1'b0;
                    if (k == 2 && $urandom % 2 == 0) ch_req[g] = 1'b0;
                    k++;
                    @(negedge clock);
                end
                if (k >= 80) check("fill_timeout", 32'(1), 32'(0));
                check("fill_busy", 32'(busy), 32'(1));
            end else begin
                check("hit_nomemreq", 32'(mem_req), 32'(0));
                check("hit_misscnt", 32'(miss_count), 32'(m_miss));
            end
            eb = fb(fa | 24'(ad % LINE_BYTES));
            if (g) m_held[15:8] = eb; else m_held[7:0] = eb;
            check("ack", 32'(ch_ack), 32'(1) << g);
            check("rdata", 32'(ch_rdata), 32'(m_held));
            if (!hit && !m_fpend) cl[line] = int'(ad >> OB);
            pend[g] = 1'b0;
            @(posedge clock); #1;
        end else begin
            check("idle_memreq", 32'(mem_req), 32'(0));
            @(posedge clock); #1;
        end
        flush = 1'b0;
    endtask

    task automatic req0(input logic [16:0] ad);
        pend = 2'b01; a[0] = ad; step(1'b0);
    endtask

    initial begin
        int k;
        reset_n = 1'b0; flush = 1'b0; index = 4'd0;
        ch_req = 2'b00; ch_addr = '0;
        pend = 2'b00; a[0] = '0; a[1] = '0;
        reset_model();
        repeat (3) @(posedge clock);
        #1;
        check("rst_ack", 32'(ch_ack), 32'(0));
        check("rst_rdata", 32'(ch_rdata), 32'(0));
        check("rst_memreq", 32'(mem_req), 32'(0));
        check("rst_memaddr", 32'(mem_addr), 32'(0));
        check("rst_miss", 32'(miss_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset_n = 1'b1;

        // Directed opening: fill, hit, conflict eviction, paired requests, flush.
        req0(17'h00005);
        req0(17'h00003);
        req0(17'h00200);
        req0(17'h00005);
        pend = 2'b11; a[0] = 17'h00010; a[1] = 17'h10010;
        step(1'b0);
        step(1'b0);
        flush = 1'b1; index = 4'd2; step(1'b0);
        req0(17'h00000);
        pend = 2'b01; a[0] = 17'h00000; step(1'b1);
        step(1'b0);
        req0(17'h00000);

        // Random traffic.
        for (int it = 0; it < 600; it++) begin
            for (int c = 0; c < 2; c++)
                if (!pend[c] && $urandom % 3 == 0) begin pend[c] = 1'b1; a[c] = pick(); end
            index = 4'($urandom);
            if ($urandom % 25 == 0) flush = 1'b1;
            step($urandom % 4 == 0);
        end
        while (pend != 2'b00) step(1'b0);
        step(1'b0);
        step(1'b0);

        // Reset in the middle of a line fill.
        req0(17'h00008);
        req0(17'h00009);
        ch_req = 2'b01; ch_addr = {17'd0, 17'h04000};
        k = 0;
        while (!mem_req && k < 10) begin @(posedge clock); #1; k++; end
        check("rst_fill_start", 32'(mem_req), 32'(1));
        repeat (6) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstfill_memreq", 32'(mem_req), 32'(0));
        check("rstfill_ack", 32'(ch_ack), 32'(0));
        check("rstfill_miss", 32'(miss_count), 32'(0));
        check("rstfill_busy", 32'(busy), 32'(0));
        ch_req = 2'b00;
        reset_model();
        pend = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        req0(17'h00008);
        req0(17'h00009);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
